// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready load/store port with a fixed wait-state
// latency, byte-enabled stores, access-error flagging and a saturating error count.

module dmem_lane (
    input  logic [7:0] oldByte,
    input  logic [7:0] newByte,
    input  logic       en,
    output logic [7:0] mergedByte
);
    assign mergedByte = en ? newByte : oldByte;
endmodule

module dmem_resp #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  err_count
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [31:0]     addr;
        logic [3:0][7:0] wdata;
    } reqType;

    stateType        state, stateNext;
    reqType          reqQ, txn;
    logic [3:0]      waitCnt;
    logic [AW-1:0]   idx;
    logic            addrErr, accept, enterResp;
    logic [3:0][7:0] oldWord, newWord;
    logic [31:0]     respRdata;
    logic            respErr;
    logic [7:0]      errCount;
    logic [3:0][7:0] mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = respRdata;
    assign resp_err   = respErr;
    assign err_count  = errCount;

    assign accept = req_valid && (state == IDLE);

    // With zero wait states the RESP entry edge is the acceptance edge, so the
    // live request must be used there instead of the not-yet-latched copy.
    assign txn       = (state == IDLE) ? {req_we, req_be, req_addr, req_wdata} : reqQ;
    assign idx       = txn.addr[AW+1:2];
    assign addrErr   = (txn.addr[1:0] != 2'b00) || (|txn.addr[31:AW+2]);
    assign enterResp = (stateNext == RESP);
    assign oldWord   = mem[idx];

    for (genvar i = 0; i < 4; i++) begin : gLane
        dmem_lane uLane (
            .oldByte   (oldWord[i]),
            .newByte   (txn.wdata[i]),
            .en        (txn.be[i]),
            .mergedByte(newWord[i])
        );
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (waitCnt == 4'd0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reqQ      <= '0;
            waitCnt   <= 4'd0;
            respRdata <= 32'd0;
            respErr   <= 1'b0;
            errCount  <= 8'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                reqQ    <= txn;
                waitCnt <= WAIT_LOAD;
            end else if (state == WAIT && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (enterResp) begin
                respErr   <= addrErr;
                respRdata <= addrErr ? 32'd0 : oldWord;
                if (addrErr && errCount != 8'hFF) errCount <= errCount + 8'd1;
            end else begin
                respErr   <= 1'b0;
                respRdata <= 32'd0;
            end
        end
    end

    // No reset on the array; reset only suppresses a pending store.
    always_ff @(posedge clk) begin
        if (!reset && enterResp && txn.we && !addrErr) mem[idx] <= newWord;
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a WAIT_CYCLES=2 instance for function/errors/reset
// and a WAIT_CYCLES=0 instance for back-to-back handshake timing.

module tb_dmem_resp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0, reqWe = 1'b0;
    logic [3:0]  reqBe = 4'h0;
    logic [31:0] reqAddr = 32'h0, reqWdata = 32'h0;
    logic        reqReady, respValid, respErr;
    logic [31:0] respRdata;
    logic [7:0]  errCount;

    logic        reqValid0 = 1'b0;
    logic        reqReady0, respValid0, respErr0;
    logic [31:0] respRdata0;
    logic [7:0]  errCount0;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_we(reqWe), .req_be(reqBe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(reqReady),
        .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr),
        .err_count(errCount)
    );

    dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(reqValid0), .req_we(1'b0), .req_be(4'h0),
        .req_addr(32'h4), .req_wdata(32'h0), .req_ready(reqReady0),
        .resp_valid(respValid0), .resp_rdata(respRdata0), .resp_err(respErr0),
        .err_count(errCount0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE; returns response fields, edges from
    // acceptance to the response cycle, and whether idle outputs stayed clean.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat, output logic quiet);
        reqValid = 1'b1; reqWe = we; reqBe = be; reqAddr = addr; reqWdata = wdata;
        tick();
        reqValid = 1'b0;
        lat = 1;
        quiet = 1'b1;
        while (!respValid && lat < 20) begin
            if (reqReady || respRdata != 0 || respErr) quiet = 1'b0;
            tick();
            lat++;
        end
        if (reqReady) quiet = 1'b0;
        rd = respRdata;
        er = respErr;
        tick();
    endtask

    logic [31:0] rd;
    logic        er, quiet;
    int          lat, accepts, resps;
    logic [5:0]  rdyBits, vldBits;
    logic [31:0] firstRd;
    logic        firstEr, sawResp;

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check("rst_ready", reqReady, 1);
        check("rst_valid", respValid, 0);
        check("rst_rdata", respRdata, 0);
        check("rst_err", respErr, 0);
        check("rst_errcnt", errCount, 0);

        // zero wait states, request held: accepts at cycles 0,2,4
        reqValid0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rdyBits[i] = reqReady0;
            vldBits[i] = respValid0;
            tick();
        end
        reqValid0 = 1'b0;
        check("w0_ready_pat", rdyBits, 6'b010101);
        check("w0_resp_pat", vldBits, 6'b101010);
        tick();

        // full-word store, response latency and ready gap
        xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat, quiet);
        check("st_latency", lat, 3);
        check("st_err", er, 0);
        check("st_quiet", quiet, 1);
        check("after_valid", respValid, 0);
        check("after_ready", reqReady, 1);
        xact(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, quiet);
        check("ld_10", rd, 32'hDEADBEEF);
        check("ld_latency", lat, 3);

        // byte enables
        xact(1'b1, 4'hF, 32'h14, 32'h11223344, rd, er, lat, quiet);
        xact(1'b1, 4'b0101, 32'h14, 32'hAABBCCDD, rd, er, lat, quiet);
        check("be_prewrite", rd, 32'h11223344);
        xact(1'b0, 4'h0, 32'h14, 32'h0, rd, er, lat, quiet);
        check("be_merged", rd, 32'h11BB33DD);
        xact(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, rd, er, lat, quiet);
        check("be0_rdata", rd, 32'h11BB33DD);
        check("be0_err", er, 0);
        xact(1'b0, 4'h0, 32'h14, 32'h0, rd, er, lat, quiet);
        check("be0_nochange", rd, 32'h11BB33DD);

        // errors: misaligned load, out-of-range store aliasing word 0
        xact(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat, quiet);
        xact(1'b0, 4'h0, 32'h102, 32'h0, rd, er, lat, quiet);
        check("mis_err", er, 1);
        check("mis_rdata", rd, 0);
        xact(1'b1, 4'hF, 32'h100, 32'h12345678, rd, er, lat, quiet);
        check("oor_err", er, 1);
        check("oor_rdata", rd, 0);
        check("errcnt_2", errCount, 2);
        xact(1'b1, 4'hF, 32'h16, 32'h87654321, rd, er, lat, quiet);
        check("mis_st_err", er, 1);
        xact(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat, quiet);
        check("oor_nowrite", rd, 32'hCAFEF00D);
        check("oor_ok_err", er, 0);
        xact(1'b0, 4'h0, 32'h14, 32'h0, rd, er, lat, quiet);
        check("mis_nowrite", rd, 32'h11BB33DD);
        check("errcnt_3", errCount, 3);

        for (int i = 0; i < 252; i++) xact(1'b0, 4'h0, 32'h8000_0000, 32'h0, rd, er, lat, quiet);
        check("errcnt_255", errCount, 255);
        for (int i = 0; i < 4; i++) xact(1'b0, 4'h0, 32'h1, 32'h0, rd, er, lat, quiet);
        check("errcnt_sat", errCount, 255);
        check("sat_err", er, 1);

        // reset during WAIT drops the store
        xact(1'b1, 4'hF, 32'h20, 32'h0BADC0DE, rd, er, lat, quiet);
        reqValid = 1'b1; reqWe = 1'b1; reqBe = 4'hF; reqAddr = 32'h20; reqWdata = 32'hFFFFFFFF;
        tick();
        reqValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_ready", reqReady, 1);
        check("rstw_errcnt", errCount, 0);
        sawResp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (respValid) sawResp = 1'b1;
            tick();
        end
        check("rstw_noresp", sawResp, 0);
        xact(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, quiet);
        check("rstw_mem", rd, 32'h0BADC0DE);

        // reset on the edge that would enter RESP
        reqValid = 1'b1; reqWe = 1'b1; reqBe = 4'hF; reqAddr = 32'h20; reqWdata = 32'h13579BDF;
        tick();
        reqValid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstr_valid", respValid, 0);
        xact(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, quiet);
        check("rstr_mem", rd, 32'h0BADC0DE);

        // hold/ignore: new request held through WAIT, load in flight unaffected
        reqValid = 1'b1; reqWe = 1'b0; reqBe = 4'h0; reqAddr = 32'h14; reqWdata = 32'h0;
        tick();
        reqWe = 1'b1; reqBe = 4'hF; reqAddr = 32'h30; reqWdata = 32'h5A5A5A5A;
        accepts = 0; resps = 0; firstRd = 32'h0; firstEr = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (respValid) begin
                if (resps == 0) begin firstRd = respRdata; firstEr = respErr; end
                resps++;
            end
            if (reqValid && reqReady) begin
                accepts++;
                tick();
                reqValid = 1'b0;
            end else begin
                tick();
            end
        end
        reqValid = 1'b0;
        check("hold_accepts", accepts, 1);
        check("hold_resps", resps, 2);
        check("hold_inflight", firstRd, 32'h11BB33DD);
        check("hold_inflight_err", firstEr, 0);
        xact(1'b0, 4'h0, 32'h30, 32'h0, rd, er, lat, quiet);
        check("hold_stored", rd, 32'h5A5A5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
